// File: rtl/shape_raster_pkg.sv
// Shared definitions for the shape rasteriser: draw-mode encodings, the default
// coordinate width and the FSM state type used by the top-level walker.
package shape_raster_pkg;

    localparam int unsigned COORD_W_DEFAULT = 8;

    localparam logic [1:0] MODE_FREE = 2'd0;
    localparam logic [1:0] MODE_RECT = 2'd1;
    localparam logic [1:0] MODE_LINE = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StLine,
        StRTop,
        StRRight,
        StRBottom,
        StRLeft
    } state_t;

endpackage

// File: rtl/shape_raster_line_stepper.sv
// Bresenham line core. 'load' captures the endpoints and initialises the
// error term; each 'step' advances (x, y) by one Bresenham step.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   load            capture ax/ay/bx/by, current point becomes (ax, ay)
//   step            advance to the next point on the line
//   ax, ay, bx, by  line start and end
//   x, y            current point
//   last            current point equals the end point
module shape_raster_line_stepper #(
    parameter int unsigned COORD_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [COORD_W-1:0] ax,
    input  logic [COORD_W-1:0] ay,
    input  logic [COORD_W-1:0] bx,
    input  logic [COORD_W-1:0] by,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               last
);
    // Error term needs sign plus one bit of headroom over a coordinate span.
    localparam int unsigned EW = COORD_W + 2;
    localparam logic [COORD_W-1:0] CoordOne = COORD_W'(1);

    logic [COORD_W-1:0] x_q, y_q, ex_q, ey_q;
    logic signed [EW-1:0] dx_q, dy_q, err_q, err_nxt;
    logic sx_neg_q, sy_neg_q;
    logic [COORD_W-1:0] adx, ady;
    logic signed [EW:0] e2, dx_e, dy_e;
    logic step_x, step_y;

    always_comb begin
        adx     = (bx >= ax) ? bx - ax : ax - bx;
        ady     = (by >= ay) ? by - ay : ay - by;
        e2      = {err_q, 1'b0};
        dx_e    = {dx_q[EW-1], dx_q};
        dy_e    = {dy_q[EW-1], dy_q};
        step_x  = (e2 >= dy_e);
        step_y  = (e2 <= dx_e);
        // Both corrections use the same e2, so they may apply together.
        err_nxt = err_q;
        if (step_x) err_nxt = err_nxt + dy_q;
        if (step_y) err_nxt = err_nxt + dx_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q      <= '0;
            y_q      <= '0;
            ex_q     <= '0;
            ey_q     <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
        end else if (load) begin
            x_q      <= ax;
            y_q      <= ay;
            ex_q     <= bx;
            ey_q     <= by;
            dx_q     <= $signed({2'b00, adx});
            dy_q     <= -$signed({2'b00, ady});
            err_q    <= $signed({2'b00, adx}) - $signed({2'b00, ady});
            sx_neg_q <= (bx < ax);
            sy_neg_q <= (by < ay);
        end else if (step) begin
            if (step_x) x_q <= sx_neg_q ? x_q - CoordOne : x_q + CoordOne;
            if (step_y) y_q <= sy_neg_q ? y_q - CoordOne : y_q + CoordOne;
            err_q <= err_nxt;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = (x_q == ex_q) && (y_q == ey_q);

endmodule

// File: rtl/shape_raster.sv
// Shape rasteriser: on a trigger, streams the pixels of a rectangle outline
// or a Bresenham line over a valid/ready handshake.
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   shape_trigger, mode         one-cycle draw request and its mode
//   point_a_x/y, point_b_x/y    the two captured points
//   pix_valid, pix_ready        pixel handshake
//   pix_x, pix_y                pixel coordinate, held while stalled
//   busy                        shape in progress
//   done                        one-cycle pulse after the last transfer
//   dropped                     one-cycle pulse when a trigger arrives while busy
module shape_raster
    import shape_raster_pkg::*;
#(
    parameter int unsigned COORD_W = COORD_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shape_trigger,
    input  logic [1:0]         mode,
    input  logic [COORD_W-1:0] point_a_x,
    input  logic [COORD_W-1:0] point_a_y,
    input  logic [COORD_W-1:0] point_b_x,
    input  logic [COORD_W-1:0] point_b_y,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               busy,
    output logic               done,
    output logic               dropped
);
    localparam logic [COORD_W-1:0] CoordOne = COORD_W'(1);

    state_t             state_q;
    logic [1:0]         mode_q;
    logic [COORD_W-1:0] ax_q, ay_q, bx_q, by_q;
    logic [COORD_W-1:0] x0_q, x1_q, y0_q, y1_q;
    logic [COORD_W-1:0] cx_q, cy_q;
    // Set once the final pixel of the shape sits in the output register.
    logic               last_q;

    logic [COORD_W-1:0] min_x, max_x, min_y, max_y, w, h;
    logic [COORD_W-1:0] stp_x, stp_y, gen_x, gen_y;
    logic               stp_last, stp_load, stp_step;
    logic               advance, drawing, accept;

    always_comb begin
        min_x    = (ax_q < bx_q) ? ax_q : bx_q;
        max_x    = (ax_q < bx_q) ? bx_q : ax_q;
        min_y    = (ay_q < by_q) ? ay_q : by_q;
        max_y    = (ay_q < by_q) ? by_q : ay_q;
        w        = x1_q - x0_q;
        h        = y1_q - y0_q;
        // Output register can take a new pixel when empty or being consumed.
        advance  = !pix_valid || pix_ready;
        drawing  = state_q inside {StLine, StRTop, StRRight, StRBottom, StRLeft};
        accept   = shape_trigger && ((mode == MODE_RECT) || (mode == MODE_LINE));
        gen_x    = (state_q == StLine) ? stp_x : cx_q;
        gen_y    = (state_q == StLine) ? stp_y : cy_q;
        stp_load = (state_q == StSetup);
        stp_step = (state_q == StLine) && advance && !last_q && !stp_last;
    end

    assign busy = (state_q != StIdle);

    shape_raster_line_stepper #(
        .COORD_W(COORD_W)
    ) u_line_stepper (
        .clk (clk),
        .rst (rst),
        .load(stp_load),
        .step(stp_step),
        .ax  (ax_q),
        .ay  (ay_q),
        .bx  (bx_q),
        .by  (by_q),
        .x   (stp_x),
        .y   (stp_y),
        .last(stp_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            mode_q    <= MODE_FREE;
            ax_q      <= '0;
            ay_q      <= '0;
            bx_q      <= '0;
            by_q      <= '0;
            x0_q      <= '0;
            x1_q      <= '0;
            y0_q      <= '0;
            y1_q      <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            last_q    <= 1'b0;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            done      <= 1'b0;
            dropped   <= 1'b0;
        end else begin
            done    <= 1'b0;
            dropped <= shape_trigger && (state_q != StIdle);
            if (state_q == StIdle) begin
                if (accept) begin
                    mode_q  <= mode;
                    ax_q    <= point_a_x;
                    ay_q    <= point_a_y;
                    bx_q    <= point_b_x;
                    by_q    <= point_b_y;
                    state_q <= StSetup;
                end
            end else if (state_q == StSetup) begin
                x0_q    <= min_x;
                x1_q    <= max_x;
                y0_q    <= min_y;
                y1_q    <= max_y;
                cx_q    <= min_x;
                cy_q    <= min_y;
                last_q  <= 1'b0;
                state_q <= (mode_q == MODE_LINE) ? StLine : StRTop;
            end else if (drawing && advance) begin
                if (last_q) begin
                    // Final pixel was just accepted.
                    pix_valid <= 1'b0;
                    last_q    <= 1'b0;
                    done      <= 1'b1;
                    state_q   <= StIdle;
                end else begin
                    pix_valid <= 1'b1;
                    pix_x     <= gen_x;
                    pix_y     <= gen_y;
                    // Empty edges are skipped by jumping straight to the next
                    // edge's first pixel, so the stream never bubbles.
                    case (state_q)
                        StLine: begin
                            if (stp_last) last_q <= 1'b1;
                        end
                        StRTop: begin
                            if (cx_q != x1_q) begin
                                cx_q <= cx_q + CoordOne;
                            end else if (h != '0) begin
                                state_q <= StRRight;
                                cy_q    <= y0_q + CoordOne;
                            end else begin
                                last_q <= 1'b1;
                            end
                        end
                        StRRight: begin
                            if (cy_q != y1_q) begin
                                cy_q <= cy_q + CoordOne;
                            end else if (w != '0) begin
                                state_q <= StRBottom;
                                cx_q    <= x1_q - CoordOne;
                            end else begin
                                last_q <= 1'b1;
                            end
                        end
                        StRBottom: begin
                            if (cx_q != x0_q) begin
                                cx_q <= cx_q - CoordOne;
                            end else if (h > CoordOne) begin
                                state_q <= StRLeft;
                                cy_q    <= y1_q - CoordOne;
                            end else begin
                                last_q <= 1'b1;
                            end
                        end
                        StRLeft: begin
                            if (cy_q != y0_q + CoordOne) cy_q <= cy_q - CoordOne;
                            else                         last_q <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_shape_raster.sv
module tb_shape_raster;

    logic       clk = 1'b0;
    logic       rst;
    logic       shape_trigger;
    logic [1:0] mode;
    logic [7:0] point_a_x, point_a_y, point_b_x, point_b_y;
    logic       pix_valid, pix_ready;
    logic [7:0] pix_x, pix_y;
    logic       busy, done, dropped;

    always #5 clk = ~clk;

    shape_raster #(
        .COORD_W(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .shape_trigger(shape_trigger),
        .mode         (mode),
        .point_a_x    (point_a_x),
        .point_a_y    (point_a_y),
        .point_b_x    (point_b_x),
        .point_b_y    (point_b_y),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .busy         (busy),
        .done         (done),
        .dropped      (dropped)
    );

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
    } pix_t;

    typedef struct {
        logic [1:0] mode;
        int ax, ay, bx, by;
        int n;
        int px[10];
        int py[10];
    } vec_t;

    localparam int NVEC = 8;
    vec_t vecs[NVEC];
    pix_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic stall_q = 1'b0;
    pix_t held_q;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard side: a transfer happens at the next posedge when valid and
    // ready are both high at the negedge (inputs change only just after posedge).
    always @(negedge clk) begin : monitor
        pix_t got;
        pix_t want;
        if (rst) begin
            stall_q <= 1'b0;
        end else begin
            if (stall_q) begin
                check("stall_valid_held", int'(pix_valid), 1);
                check("stall_xy_held", int'({pix_x, pix_y}), int'(held_q));
            end
            stall_q <= pix_valid && !pix_ready;
            held_q  <= {pix_x, pix_y};
            if (pix_valid && pix_ready) begin
                got = {pix_x, pix_y};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_pixel: got (%0d,%0d) expected none", pix_x, pix_y);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        errors++;
                        $display("FAIL pixel: got (%0d,%0d) expected (%0d,%0d)",
                                 got.x, got.y, want.x, want.y);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fire(input logic [1:0] m, input int a_x, input int a_y,
                        input int b_x, input int b_y);
        shape_trigger = 1'b1;
        mode          = m;
        point_a_x     = 8'(a_x);
        point_a_y     = 8'(a_y);
        point_b_x     = 8'(b_x);
        point_b_y     = 8'(b_y);
        tick();
        shape_trigger = 1'b0;
    endtask

    task automatic push_vec(input int idx);
        for (int i = 0; i < vecs[idx].n; i++)
            exp_q.push_back({8'(vecs[idx].px[i]), 8'(vecs[idx].py[i])});
    endtask

    task automatic wait_done(input string name, input int budget, output int took);
        int k;
        k = 0;
        while (!done && k < budget) begin
            tick();
            k++;
        end
        took = k;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, budget);
        end else begin
            check({name, "_done_busy_valid"}, int'({busy, pix_valid}), 0);
            check({name, "_queue_empty"}, exp_q.size(), 0);
        end
    endtask

    task automatic run_vec(input int idx);
        string nm;
        int took;
        nm = $sformatf("vec%0d", idx);
        push_vec(idx);
        fire(vecs[idx].mode, vecs[idx].ax, vecs[idx].ay, vecs[idx].bx, vecs[idx].by);
        check({nm, "_busy_after_trigger"}, int'({busy, pix_valid}), 2);
        tick();
        check({nm, "_valid_k1"}, int'(pix_valid), 0);
        tick();
        check({nm, "_valid_k2"}, int'(pix_valid), 1);
        wait_done(nm, 40, took);
        check({nm, "_cycles_to_done"}, took, vecs[idx].n);
        tick();
        check({nm, "_done_one_cycle"}, int'(done), 0);
    endtask

    initial begin : global_timeout
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int took;
        int k;
        rst           = 1'b1;
        shape_trigger = 1'b0;
        mode          = 2'd0;
        point_a_x     = '0;
        point_a_y     = '0;
        point_b_x     = '0;
        point_b_y     = '0;
        pix_ready     = 1'b1;

        vecs[0] = '{mode: 2'd1, ax: 2, ay: 3, bx: 5, by: 5, n: 10,
                    px: '{2, 3, 4, 5, 5, 5, 4, 3, 2, 2}, py: '{3, 3, 3, 3, 4, 5, 5, 5, 5, 4}};
        vecs[1] = '{mode: 2'd2, ax: 0, ay: 0, bx: 6, by: 3, n: 7,
                    px: '{0, 1, 2, 3, 4, 5, 6, 0, 0, 0}, py: '{0, 1, 1, 2, 2, 3, 3, 0, 0, 0}};
        vecs[2] = '{mode: 2'd2, ax: 10, ay: 10, bx: 10, by: 10, n: 1,
                    px: '{10, 0, 0, 0, 0, 0, 0, 0, 0, 0}, py: '{10, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        vecs[3] = '{mode: 2'd1, ax: 7, ay: 9, bx: 7, by: 6, n: 4,
                    px: '{7, 7, 7, 7, 0, 0, 0, 0, 0, 0}, py: '{6, 7, 8, 9, 0, 0, 0, 0, 0, 0}};
        vecs[4] = '{mode: 2'd1, ax: 255, ay: 255, bx: 255, by: 255, n: 1,
                    px: '{255, 0, 0, 0, 0, 0, 0, 0, 0, 0}, py: '{255, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        vecs[5] = '{mode: 2'd1, ax: 1, ay: 1, bx: 0, by: 0, n: 4,
                    px: '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0}, py: '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0}};
        vecs[6] = '{mode: 2'd2, ax: 9, ay: 2, bx: 3, by: 0, n: 7,
                    px: '{9, 8, 7, 6, 5, 4, 3, 0, 0, 0}, py: '{2, 2, 1, 1, 1, 0, 0, 0, 0, 0}};
        vecs[7] = '{mode: 2'd1, ax: 5, ay: 2, bx: 1, by: 2, n: 5,
                    px: '{1, 2, 3, 4, 5, 0, 0, 0, 0, 0}, py: '{2, 2, 2, 2, 2, 0, 0, 0, 0, 0}};

        tick();
        tick();
        rst = 1'b0;
        check("reset_flags", int'({pix_valid, busy, done, dropped}), 0);
        check("reset_pix_x", int'(pix_x), 0);
        check("reset_pix_y", int'(pix_y), 0);

        for (int i = 0; i < NVEC; i++) run_vec(i);

        // Backpressure on the full anti-diagonal.
        for (int i = 0; i < 256; i++) exp_q.push_back({8'(255 - i), 8'(i)});
        fire(2'd2, 255, 0, 0, 255);
        k = 0;
        while (!done && k < 3000) begin
            pix_ready = ($urandom_range(0, 2) != 0);
            tick();
            k++;
        end
        pix_ready = 1'b1;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL backpressure_timeout: got no done expected done");
        end
        check("backpressure_queue_empty", exp_q.size(), 0);
        tick();

        // Trigger while busy is dropped; original rectangle completes unchanged.
        push_vec(0);
        fire(2'd1, 2, 3, 5, 5);
        tick();
        tick();
        fire(2'd2, 0, 0, 9, 9);
        check("dropped_pulse", int'(dropped), 1);
        tick();
        check("dropped_one_cycle", int'(dropped), 0);
        wait_done("busy_drop", 40, took);
        check("busy_drop_cycles", took, 8);
        tick();
        check("busy_drop_no_restart", int'(busy), 0);

        // Modes 0 and 3 produce no activity.
        fire(2'd0, 1, 1, 4, 4);
        for (int i = 0; i < 3; i++) begin
            check("mode0_idle", int'({busy, pix_valid, done, dropped}), 0);
            tick();
        end
        fire(2'd3, 1, 1, 4, 4);
        for (int i = 0; i < 3; i++) begin
            check("mode3_idle", int'({busy, pix_valid, done, dropped}), 0);
            tick();
        end

        // Trigger in the done cycle starts the next shape.
        push_vec(1);
        fire(2'd2, 0, 0, 6, 3);
        wait_done("pre_retrigger", 40, took);
        push_vec(4);
        fire(2'd1, 255, 255, 255, 255);
        check("retrigger_busy", int'({busy, dropped}), 2);
        wait_done("retrigger", 40, took);
        check("retrigger_cycles", took, 3);
        tick();

        // Reset mid-rectangle abandons it with no done pulse.
        push_vec(0);
        fire(2'd1, 2, 3, 5, 5);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset_flags", int'({pix_valid, busy, done}), 0);
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            check("midreset_quiet", int'({busy, done}), 0);
            tick();
        end
        run_vec(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
